// File: rtl/sixteen_one_pkg.sv
// Shared constants and helpers for the sixteen_one selector.
//   N_IN   : number of data channels
//   SEL_W  : width of the channel select
//   MUX_W  : fan-in of one mux4_1 leaf
//   N_LEAF : number of first-level mux4_1 instances
package sixteen_one_pkg;

  localparam int N_IN   = 16;
  localparam int SEL_W  = 4;
  localparam int MUX_W  = 4;
  localparam int MUX_SW = 2;
  localparam int N_LEAF = N_IN / MUX_W;

  // One-hot decode of a channel select.
  function automatic logic [N_IN-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    logic [N_IN-1:0] one;
    one = {{(N_IN-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/sixteen_one_mux4_1.sv
// mux4_1: 4-to-1 single-bit multiplexer, the leaf of the selector tree.
// Ports:
//   d_i [3:0] : data inputs
//   s_i [1:0] : select
//   y_o       : d_i[s_i]
module mux4_1
  import sixteen_one_pkg::*;
(
  input  logic [MUX_W-1:0]  d_i,
  input  logic [MUX_SW-1:0] s_i,
  output logic              y_o
);

  // Select one of the four data bits.
  always_comb begin
    y_o = 1'b0;
    case (s_i)
      2'd0:    y_o = d_i[0];
      2'd1:    y_o = d_i[1];
      2'd2:    y_o = d_i[2];
      2'd3:    y_o = d_i[3];
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sixteen_one.sv
// sixteen_one: 16-to-1 bit selector with a one-hot decode of the select and
// an enable-gated registered copy of the selected bit.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   a [15:0]   : data channels
//   sel [3:0]  : channel select
//   en         : capture enable for out_q
//   out        : combinational a[sel]
//   sel_onehot : combinational one-hot decode of sel
//   out_q      : registered a[sel], loaded when en is high
//   valid_q    : high when out_q was loaded on the last edge
module sixteen_one
  import sixteen_one_pkg::*;
#(
  parameter logic OUT_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  a,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             out,
  output logic [N_IN-1:0]  sel_onehot,
  output logic             out_q,
  output logic             valid_q
);

  logic [N_LEAF-1:0] leaf_s;
  logic              mux_s;
  logic              out_d;
  logic              valid_d;

  // First level: each leaf picks within its group of four using sel[1:0].
  for (genvar g = 0; g < N_LEAF; g++) begin : g_leaf
    mux4_1 u_leaf (
      .d_i (a[g*MUX_W +: MUX_W]),
      .s_i (sel[MUX_SW-1:0]),
      .y_o (leaf_s[g])
    );
  end

  // Second level: pick the group using sel[3:2].
  mux4_1 u_root (
    .d_i (leaf_s),
    .s_i (sel[SEL_W-1:MUX_SW]),
    .y_o (mux_s)
  );

  assign out        = mux_s;
  assign sel_onehot = sel_to_onehot(sel);

  // Next-state for the registered copy: load on enable, otherwise hold.
  always_comb begin
    out_d   = out_q;
    valid_d = en;
    if (en) begin
      out_d = mux_s;
    end else begin
      out_d = out_q;
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= OUT_RST;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_sixteen_one.sv
module tb_sixteen_one;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [3:0]  sel;
  logic        en;
  logic        out;
  logic [15:0] sel_onehot;
  logic        out_q;
  logic        valid_q;

  int n_cmp;
  int n_err;

  // Reference model state for the registered path.
  logic mdl_q;
  logic mdl_v;

  sixteen_one #(.OUT_RST(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .sel        (sel),
    .en         (en),
    .out        (out),
    .sel_onehot (sel_onehot),
    .out_q      (out_q),
    .valid_q    (valid_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: capture the chosen bit when enabled, reset clears.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_q = 1'b0;
      mdl_v = 1'b0;
    end else begin
      mdl_v = en;
      if (en) mdl_q = 1'((32'(a) >> sel) & 32'd1);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bit(input logic [15:0] av, input logic [3:0] sv);
    return (32'(av) >> sv) & 32'd1;
  endfunction

  function automatic logic [31:0] exp_onehot(input logic [3:0] sv);
    return 32'd1 << sv;
  endfunction

  task automatic check_comb(input string tag);
    check_val({tag, "_out"}, 32'(out), exp_bit(a, sel));
    check_val({tag, "_onehot"}, 32'(sel_onehot), exp_onehot(sel));
  endtask

  task automatic check_reg(input string tag);
    check_val({tag, "_out_q"}, 32'(out_q), 32'(mdl_q));
    check_val({tag, "_valid_q"}, 32'(valid_q), 32'(mdl_v));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a     = 16'h0000;
    sel   = 4'd0;
    en    = 1'b0;
    #2;
    check_val("rst_out_q", 32'(out_q), 32'd0);
    check_val("rst_valid_q", 32'(valid_q), 32'd0);
    check_comb("rst_comb");

    @(negedge clk);
    rst_n = 1'b1;

    // Alternating pattern sweep over every select value.
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      a   = 16'h5555;
      sel = 4'(s);
      #1;
      check_val("sweep_out", 32'(out), ((s % 2) == 0) ? 32'd1 : 32'd0);
      check_comb("sweep");
    end

    // Data changes between edges must show up on out at once.
    @(negedge clk);
    sel = 4'd2;
    a   = 16'h0004;
    #1;
    check_val("pat_out1", 32'(out), 32'd1);
    check_val("pat_onehot", 32'(sel_onehot), 32'h0004);
    a = 16'hFFFB;
    #1;
    check_val("pat_out0", 32'(out), 32'd0);

    // Capture then hold.
    @(negedge clk);
    en  = 1'b1;
    a   = 16'h8000;
    sel = 4'd15;
    @(negedge clk);
    check_val("cap_out_q", 32'(out_q), 32'd1);
    check_val("cap_valid_q", 32'(valid_q), 32'd1);
    check_reg("cap");
    en = 1'b0;
    a  = 16'h0000;
    @(negedge clk);
    check_val("hold_out_q", 32'(out_q), 32'd1);
    check_val("hold_valid_q", 32'(valid_q), 32'd0);

    // Asynchronous reset between edges.
    a = 16'h8000;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_q", 32'(out_q), 32'd0);
    check_val("arst_valid_q", 32'(valid_q), 32'd0);
    check_comb("arst_comb");
    en = 1'b1;
    @(negedge clk);
    check_val("arst_en_out_q", 32'(out_q), 32'd0);
    check_val("arst_en_valid_q", 32'(valid_q), 32'd0);
    sel = 4'd3;
    #1;
    check_comb("arst_sel");
    rst_n = 1'b1;

    // Randomised vectors with occasional reset pulses.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      check_reg("rnd");
      a   = 16'($urandom);
      sel = 4'($urandom_range(15, 0));
      en  = 1'($urandom_range(1, 0));
      #1;
      check_comb("rnd");
      if ($urandom_range(49, 0) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_reg("rnd_rst");
        check_comb("rnd_rst");
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    check_reg("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
